// File: rtl/cnn_fix_pkg.sv
// Fixed-point widths, limits and FSM states shared by the
// accumulate/requantize stage and its helpers.
package cnn_fix_pkg;

  localparam int PROD_W     = 24;
  localparam int PROD_FRAC  = 16;
  localparam int ACC_W      = 32;
  localparam int OUT_W      = 14;
  localparam int OUT_FRAC   = 8;
  localparam int FRAC_SHIFT = PROD_FRAC - OUT_FRAC;

  localparam int OUT_MAX = 2**(OUT_W-1) - 1;
  localparam int OUT_MIN = -(2**(OUT_W-1));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_FIN  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/cnn_mac_acc_requant_if.sv
// Control, product stream and result stream of the
// accumulate/requantize stage.
interface cnn_mac_acc_requant_if;
  import cnn_fix_pkg::*;

  logic                     start;
  logic signed [OUT_W-1:0]  bias;
  logic                     relu_en;
  logic signed [PROD_W-1:0] prod_data;
  logic                     prod_valid;
  logic                     prod_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  modport slave (
    input  start, bias, relu_en,
    input  prod_data, prod_valid,
    output prod_ready,
    output out_data, out_sat, out_valid,
    input  out_ready,
    output busy
  );

  modport master (
    output start, bias, relu_en,
    output prod_data, prod_valid,
    input  prod_ready,
    input  out_data, out_sat, out_valid,
    output out_ready,
    input  busy
  );

endinterface

// File: rtl/cnn_requant_sat.sv
// Round half-up, arithmetic shift to output format,
// saturate and optional ReLU. Purely combinational.
module cnn_requant_sat
  import cnn_fix_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  localparam logic signed [ACC_W-1:0] HALF =
    ACC_W'(2**(FRAC_SHIFT-1));
  localparam logic signed [ACC_W-1:0] HI =
    ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0] LO =
    ACC_W'(OUT_MIN);

  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] r;

  assign rnd = acc + HALF;
  assign r   = rnd >>> FRAC_SHIFT;

  always_comb begin
    out_sat  = 1'b0;
    out_data = r[OUT_W-1:0];
    if (r > HI) begin
      out_data = HI[OUT_W-1:0];
      out_sat  = 1'b1;
    end else if (r < LO) begin
      out_data = LO[OUT_W-1:0];
      out_sat  = 1'b1;
    end
    // ReLU clears the value but keeps any clamp flag
    if (relu_en && r[ACC_W-1])
      out_data = '0;
  end

endmodule

// File: rtl/cnn_mac_acc_requant.sv
// Sums one window of products plus bias and emits the
// requantized activation on a valid/ready port.
module cnn_mac_acc_requant
  import cnn_fix_pkg::*;
#(
  parameter int N_TERMS = 25
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  cnn_mac_acc_requant_if.slave  bus
);

  localparam int CNT_W =
    (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_TERMS - 1);

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic                    relu_q;
  logic signed [OUT_W-1:0] data_q;
  logic                    sat_q;

  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [OUT_W-1:0] rq_data;
  logic                    rq_sat;

  assign bias_ext = {{(ACC_W-OUT_W){bus.bias[OUT_W-1]}},
                     bus.bias};
  assign prod_ext =
    {{(ACC_W-PROD_W){bus.prod_data[PROD_W-1]}},
     bus.prod_data};

  cnn_requant_sat u_rq (
    .acc      (acc),
    .relu_en  (relu_q),
    .out_data (rq_data),
    .out_sat  (rq_sat)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      cnt    <= '0;
      relu_q <= 1'b0;
      data_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            acc    <= bias_ext <<< FRAC_SHIFT;
            cnt    <= '0;
            relu_q <= bus.relu_en;
            state  <= S_ACC;
          end
        end
        S_ACC: begin
          if (bus.prod_valid) begin
            acc <= acc + prod_ext;
            cnt <= cnt + 1'b1;
            if (cnt == LAST)
              state <= S_FIN;
          end
        end
        S_FIN: begin
          data_q <= rq_data;
          sat_q  <= rq_sat;
          state  <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // all outputs decode from registers only
  assign bus.prod_ready = (state == S_ACC);
  assign bus.out_valid  = (state == S_OUT);
  assign bus.busy       = (state != S_IDLE);
  assign bus.out_data   = data_q;
  assign bus.out_sat    = sat_q;

endmodule
